// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button front end. Brings an asynchronous pad into the
// clk domain, debounces it, and produces press, release and auto-repeat strobes.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active low
//   btn_in       raw button pad (asynchronous, active high, bouncy)
//   btn_level    debounced, synchronised button level
//   btn_pulse    1-cycle strobe on debounced press and on each auto-repeat
//   btn_release  1-cycle strobe on debounced release
//   btn_repeat   high while auto-repeating
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned CNT_W         = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release,
  output logic btn_repeat
);

  localparam logic [CNT_W-1:0] DEB_T    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_T  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_T = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state;
  logic             s1, s2;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             deb_done;
  logic             rise;
  logic             fall;

  // Level change accepted on this edge; the FSM reacts on the same edge so
  // press/release strobes line up with the btn_level transition.
  always_comb begin
    deb_done = (s2 != btn_level) && (deb_cnt == DEB_T);
    rise     = deb_done && s2;
    fall     = deb_done && !s2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      deb_cnt     <= '0;
      rep_cnt     <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
      state       <= IDLE;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;

      // Debounce: count consecutive cycles that s2 disagrees with btn_level.
      if (s2 == btn_level) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        btn_level <= s2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end

      // Release takes priority over any repeat expiry on the same edge.
      if (fall) begin
        state       <= IDLE;
        rep_cnt     <= '0;
        btn_release <= 1'b1;
        btn_repeat  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state     <= HOLD;
              rep_cnt   <= '0;
              btn_pulse <= 1'b1;
            end
          end
          HOLD: begin
            if (REPEAT_EN != 0) begin
              if (rep_cnt == DELAY_T) begin
                state      <= REPEAT;
                rep_cnt    <= '0;
                btn_pulse  <= 1'b1;
                btn_repeat <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + CNT_W'(1);
              end
            end
          end
          REPEAT: begin
            if (rep_cnt == PERIOD_T) begin
              rep_cnt   <= '0;
              btn_pulse <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + CNT_W'(1);
            end
          end
          default: begin
            state      <= IDLE;
            rep_cnt    <= '0;
            btn_repeat <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=5. u1 has auto-repeat enabled, u0 has it disabled.
// Outputs are compared as {btn_level, btn_pulse, btn_release, btn_repeat}.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic btn1, btn0;
  logic lvl1, pls1, rel1, rpt1;
  logic lvl0, pls0, rel0, rpt0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEB_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .CNT_W(31)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn1),
    .btn_level(lvl1), .btn_pulse(pls1), .btn_release(rel1), .btn_repeat(rpt1)
  );

  btn_conditioner #(
    .DEB_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .CNT_W(31)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn0),
    .btn_level(lvl0), .btn_pulse(pls0), .btn_release(rel0), .btn_repeat(rpt0)
  );

  function automatic logic [3:0] out1();
    return {lvl1, pls1, rel1, rpt1};
  endfunction

  function automatic logic [3:0] out0();
    return {lvl0, pls0, rel0, rpt0};
  endfunction

  // Expected u1 outputs k edges after the press pulse while still held.
  function automatic logic [3:0] held_exp(int k);
    logic p;
    p = (k == 0) || (k >= 20 && ((k - 20) % 5) == 0);
    return {1'b1, p, 1'b0, (k >= 20)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn1  = 1'b1;
    btn0  = 1'b0;

    // T1: reset with button held, then fresh press on edge 6.
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t1_reset_%0d", i), out1(), 4'b0000);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("t1_wait_e%0d", e), out1(), 4'b0000);
    end
    tick();
    chk("t1_press_e6", out1(), 4'b1100);

    // T3/T4: hold; repeats at +20 then every 5. Drop after +59 so the first
    // low sample is +60 and the fall lands on +65, a repeat expiry.
    for (int k = 1; k <= 59; k++) begin
      tick();
      chk($sformatf("t3_hold_k%0d", k), out1(), held_exp(k));
    end
    btn1 = 1'b0;
    for (int k = 60; k <= 64; k++) begin
      tick();
      chk($sformatf("t4_falling_k%0d", k), out1(), held_exp(k));
    end
    tick();
    chk("t4_release_k65", out1(), 4'b0010);
    tick();
    chk("t4_after_release", out1(), 4'b0000);

    // T2a: 3-cycle glitch gives nothing.
    btn1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) btn1 = 1'b0;
      tick();
      chk($sformatf("t2_glitch_%0d", i), out1(), 4'b0000);
    end

    // T2b: bounce 1,0,1,1,0 then steady 1: press on edge 11 of the sequence.
    for (int e = 1; e <= 10; e++) begin
      btn1 = (e == 1 || e == 3 || e == 4 || e >= 6);
      tick();
      chk($sformatf("t2_bounce_e%0d", e), out1(), 4'b0000);
    end
    tick();
    chk("t2_press_e11", out1(), 4'b1100);
    tick();
    chk("t2_hold_e12", out1(), 4'b1000);
    btn1 = 1'b0;
    for (int e = 13; e <= 17; e++) begin
      tick();
      chk($sformatf("t2_fall_e%0d", e), out1(), 4'b1000);
    end
    tick();
    chk("t2_release_e18", out1(), 4'b0010);
    tick();
    chk("t2_idle_e19", out1(), 4'b0000);

    // T5: REPEAT_EN=0 unit, held 100+ cycles: single pulse, no repeat.
    btn0 = 1'b1;
    for (int e = 1; e <= 106; e++) begin
      tick();
      chk($sformatf("t5_u0_e%0d", e), out0(),
          (e < 6) ? 4'b0000 : (e == 6) ? 4'b1100 : 4'b1000);
    end
    chk("t5_u1_quiet", out1(), 4'b0000);
    btn0 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("t5_u0_rel_e%0d", e), out0(),
          (e < 6) ? 4'b1000 : (e == 6) ? 4'b0010 : 4'b0000);
    end

    // T6: reset while repeating with button held, then a fresh press.
    btn1 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("t6_wait_e%0d", e), out1(), 4'b0000);
    end
    for (int k = 0; k <= 22; k++) begin
      tick();
      chk($sformatf("t6_pre_k%0d", k), out1(), held_exp(k));
    end
    rst_n = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk($sformatf("t6_reset_%0d", i), out1(), 4'b0000);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("t6_rewait_e%0d", e), out1(), 4'b0000);
    end
    for (int k = 0; k <= 26; k++) begin
      tick();
      chk($sformatf("t6_post_k%0d", k), out1(), held_exp(k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
